// File: rtl/keypad_scan_param.sv
// Debounced row/column keypad scanner with optional auto-repeat.
// Ports: clk, rst_n (async, active-low), row[ROWS] (active-low in),
//        col[COLS] (active-low drive), key_valid / key_release (1-clk pulses),
//        key_code[KW] (last accepted key), key_held (level).
module keypad_scan_param #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int DEB_TICKS      = 20,
    parameter int REPEAT_EN      = 0,
    parameter int REP_DLY_TICKS  = 500,
    parameter int REP_RATE_TICKS = 100,
    localparam int KW = (ROWS * COLS > 2) ? $clog2(ROWS * COLS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output logic            key_valid,
    output logic [KW-1:0]   key_code,
    output logic            key_release,
    output logic            key_held
);

    localparam int TICK_DIV = (CLK_HZ / SCAN_HZ < 2) ? 2 : CLK_HZ / SCAN_HZ;
    localparam int TW       = $clog2(TICK_DIV);
    localparam int DW       = (DEB_TICKS > 1) ? $clog2(DEB_TICKS + 1) : 1;
    localparam int REP_MAX  = (REP_DLY_TICKS > REP_RATE_TICKS) ?
                              REP_DLY_TICKS : REP_RATE_TICKS;
    localparam int RW       = (REP_MAX > 1) ? $clog2(REP_MAX + 1) : 1;
    localparam int CW       = (COLS > 2) ? $clog2(COLS) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PDEB = 3'd1,
        SCAN = 3'd2,
        HELD = 3'd3,
        RDEB = 3'd4
    } state_t;

    logic [TW-1:0] div_q;
    logic          tick;

    assign tick = (div_q == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    div_q <= '0;
        else if (tick) div_q <= '0;
        else           div_q <= div_q + TW'(1);
    end

    state_t        state_q, state_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [CW-1:0] cidx_q, cidx_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          late_q, late_d;
    logic [KW-1:0] code_q, code_d;
    logic          valid_q, valid_d;
    logic          rel_q, rel_d;
    logic          held_q, held_d;

    logic          row_idle;
    logic [KW-1:0] hit_code;
    logic [RW-1:0] rep_inc;
    logic [RW-1:0] rep_tgt;

    assign row_idle = &row;
    assign rep_inc  = rep_q + RW'(1);
    // First repeat waits the long delay, later ones use the rate.
    assign rep_tgt  = late_q ? RW'(REP_RATE_TICKS) : RW'(REP_DLY_TICKS);

    // Descending loop so the lowest low row wins.
    always_comb begin
        hit_code = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!row[i]) hit_code = KW'(i * COLS) + KW'(cidx_q);
        end
    end

    assign col         = (state_q == SCAN) ? ~(COLS'(1) << cidx_q) : '0;
    assign key_valid   = valid_q;
    assign key_release = rel_q;
    assign key_code    = code_q;
    assign key_held    = held_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            deb_q   <= '0;
            cidx_q  <= '0;
            rep_q   <= '0;
            late_q  <= 1'b0;
            code_q  <= '0;
            valid_q <= 1'b0;
            rel_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            cidx_q  <= cidx_d;
            rep_q   <= rep_d;
            late_q  <= late_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            rel_q   <= rel_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        cidx_d  = cidx_q;
        rep_d   = rep_q;
        late_d  = late_q;
        code_d  = code_q;
        valid_d = 1'b0;
        rel_d   = 1'b0;
        held_d  = held_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!row_idle) begin
                        state_d = PDEB;
                        deb_d   = DW'(1);
                    end
                end
                PDEB: begin
                    if (row_idle) begin
                        state_d = IDLE;
                        deb_d   = '0;
                    end else if (deb_q >= DW'(DEB_TICKS - 1)) begin
                        state_d = SCAN;
                        deb_d   = '0;
                        cidx_d  = '0;
                    end else begin
                        deb_d = deb_q + DW'(1);
                    end
                end
                SCAN: begin
                    if (!row_idle) begin
                        state_d = HELD;
                        code_d  = hit_code;
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                        rep_d   = '0;
                        late_d  = 1'b0;
                        cidx_d  = '0;
                    end else if (cidx_q == CW'(COLS - 1)) begin
                        state_d = IDLE;
                        cidx_d  = '0;
                    end else begin
                        cidx_d = cidx_q + CW'(1);
                    end
                end
                HELD: begin
                    if (row_idle) begin
                        state_d = RDEB;
                        deb_d   = DW'(1);
                    end else if (REPEAT_EN != 0) begin
                        // Restart at each repeat so the count never wraps.
                        if (rep_inc >= rep_tgt) begin
                            valid_d = 1'b1;
                            rep_d   = '0;
                            late_d  = 1'b1;
                        end else begin
                            rep_d = rep_inc;
                        end
                    end
                end
                RDEB: begin
                    if (!row_idle) begin
                        state_d = HELD;
                        deb_d   = '0;
                        rep_d   = '0;
                        late_d  = 1'b0;
                    end else if (deb_q >= DW'(DEB_TICKS - 1)) begin
                        state_d = IDLE;
                        deb_d   = '0;
                        rel_d   = 1'b1;
                        held_d  = 1'b0;
                    end else begin
                        deb_d = deb_q + DW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    deb_d   = '0;
                    cidx_d  = '0;
                    rep_d   = '0;
                    late_d  = 1'b0;
                    held_d  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_param.sv
// Bench for keypad_scan_param: three instances (4x4, 4x4 repeat, 2x3)
// driven by keypad models, checked against tick-arithmetic expectations.
module tb_keypad_scan_param;

    logic clk;
    logic rst_n;

    logic [3:0]  row_a, col_a, kc_a;
    logic        kv_a, kr_a, kh_a;
    logic [3:0]  row_b, col_b, kc_b;
    logic        kv_b, kr_b, kh_b;
    logic [1:0]  row_c;
    logic [2:0]  col_c, kc_c;
    logic        kv_c, kr_c, kh_c;

    logic [15:0] pr_a, pr_b;
    logic [5:0]  pr_c;

    int n_chk = 0;
    int n_err = 0;
    int nv[3];
    int nr[3];
    int ncb[3];
    int nbad[3];
    int exp_code[3];
    int bv[3];
    int br[3];
    logic pv[3];
    logic prl[3];

    keypad_scan_param #(
        .CLK_HZ(100), .SCAN_HZ(10), .ROWS(4), .COLS(4), .DEB_TICKS(20),
        .REPEAT_EN(0), .REP_DLY_TICKS(50), .REP_RATE_TICKS(10)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .row(row_a), .col(col_a),
        .key_valid(kv_a), .key_code(kc_a), .key_release(kr_a),
        .key_held(kh_a)
    );

    keypad_scan_param #(
        .CLK_HZ(100), .SCAN_HZ(10), .ROWS(4), .COLS(4), .DEB_TICKS(20),
        .REPEAT_EN(1), .REP_DLY_TICKS(50), .REP_RATE_TICKS(10)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .row(row_b), .col(col_b),
        .key_valid(kv_b), .key_code(kc_b), .key_release(kr_b),
        .key_held(kh_b)
    );

    keypad_scan_param #(
        .CLK_HZ(100), .SCAN_HZ(10), .ROWS(2), .COLS(3), .DEB_TICKS(20),
        .REPEAT_EN(0), .REP_DLY_TICKS(50), .REP_RATE_TICKS(10)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .row(row_c), .col(col_c),
        .key_valid(kv_c), .key_code(kc_c), .key_release(kr_c),
        .key_held(kh_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Switch matrix: a closed key pulls its row low when its column is low.
    always_comb begin
        row_a = '1;
        row_b = '1;
        row_c = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pr_a[r*4+c] && !col_a[c]) row_a[r] = 1'b0;
                if (pr_b[r*4+c] && !col_b[c]) row_b[r] = 1'b0;
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (pr_c[r*3+c] && !col_c[c]) row_c[r] = 1'b0;
            end
        end
    end

    task automatic mon(input int i, input logic v, input logic r,
                       input int code);
        if (v) begin
            nv[i]++;
            if (code != exp_code[i]) ncb[i]++;
        end
        if (r) nr[i]++;
        if ((v && r) || (v && pv[i]) || (r && prl[i])) nbad[i]++;
        pv[i]  = v;
        prl[i] = r;
    endtask

    always @(negedge clk) begin
        mon(0, kv_a, kr_a, int'(kc_a));
        mon(1, kv_b, kr_b, int'(kc_b));
        mon(2, kv_c, kr_c, int'(kc_c));
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (10 * n) @(negedge clk);
        #1;
    endtask

    task automatic base();
        for (int i = 0; i < 3; i++) begin
            bv[i] = nv[i];
            br[i] = nr[i];
        end
    endtask

    function automatic int dv(input int i);
        return nv[i] - bv[i];
    endfunction

    function automatic int dr(input int i);
        return nr[i] - br[i];
    endfunction

    // Accept tick = debounce (20) + column index + 1; repeats at hold
    // lengths 50, 60, 70, ... ticks past accept.
    function automatic int n_valid(input int hold, input bit rep);
        if (!rep || hold < 50) return 1;
        return 2 + (hold - 50) / 10;
    endfunction

    initial begin
        int ka, kb, kcc, p, ha, hb;
        rst_n = 1'b0;
        pr_a  = '0;
        pr_b  = '0;
        pr_c  = '0;
        for (int i = 0; i < 3; i++) exp_code[i] = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_col", int'(col_a), 0);
        chk("rst_valid", int'(kv_a), 0);
        chk("rst_release", int'(kr_a), 0);
        chk("rst_held", int'(kh_a), 0);
        chk("rst_code", int'(kc_a), 0);
        rst_n = 1'b1;
        ticks(2);

        // Clean press r1/c2 held 60 ticks.
        base();
        exp_code[0] = 6;
        pr_a[6] = 1'b1;
        ticks(22);
        chk("clean_pre_accept", dv(0), 0);
        ticks(1);
        chk("clean_accept", dv(0), 1);
        chk("clean_code", int'(kc_a), 6);
        chk("clean_held", int'(kh_a), 1);
        ticks(37);
        chk("clean_held_end", int'(kh_a), 1);
        pr_a = '0;
        ticks(19);
        chk("clean_rel_early", dr(0), 0);
        chk("clean_held_rdeb", int'(kh_a), 1);
        ticks(1);
        chk("clean_rel", dr(0), 1);
        chk("clean_held_fall", int'(kh_a), 0);
        chk("clean_one_valid", dv(0), 1);
        ticks(3);

        // Bounce that never completes debounce.
        base();
        pr_a[9] = 1'b1;
        ticks(5);
        pr_a = '0;
        ticks(3);
        pr_a[9] = 1'b1;
        ticks(12);
        pr_a = '0;
        ticks(30);
        chk("bounce_valid", dv(0), 0);
        chk("bounce_col", int'(col_a), 0);
        chk("bounce_held", int'(kh_a), 0);

        // Key opens during the scan before its column is driven.
        base();
        pr_a[3] = 1'b1;
        ticks(20);
        chk("scan_col0", int'(col_a), 4'hE);
        ticks(1);
        chk("scan_col1", int'(col_a), 4'hD);
        pr_a = '0;
        ticks(10);
        chk("scan_abort_valid", dv(0), 0);
        chk("scan_abort_col", int'(col_a), 0);

        // Release chatter inside the release debounce.
        base();
        exp_code[0] = 9;
        pr_a[9] = 1'b1;
        ticks(30);
        pr_a = '0;
        ticks(4);
        pr_a[9] = 1'b1;
        ticks(5);
        chk("chatter_no_rel", dr(0), 0);
        chk("chatter_held", int'(kh_a), 1);
        pr_a = '0;
        ticks(20);
        chk("chatter_rel", dr(0), 1);
        chk("chatter_valid", dv(0), 1);
        ticks(3);

        // Reset while held; key stays down through reset.
        base();
        pr_a[9] = 1'b1;
        ticks(30);
        chk("rsth_accept", dv(0), 1);
        rst_n = 1'b0;
        #1;
        chk("rsth_held", int'(kh_a), 0);
        chk("rsth_code", int'(kc_a), 0);
        chk("rsth_col", int'(col_a), 0);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk("rsth_no_rel", dr(0), 0);
        base();
        ticks(21);
        chk("rsth_pre_accept", dv(0), 0);
        ticks(1);
        chk("rsth_reaccept", dv(0), 1);
        chk("rsth_code2", int'(kc_a), 9);
        pr_a = '0;
        ticks(20);
        chk("rsth_rel", dr(0), 1);
        ticks(3);

        // Auto-repeat on r3/c3, held 75 ticks past accept.
        base();
        exp_code[1] = 15;
        pr_b[15] = 1'b1;
        ticks(24);
        chk("rep_accept", dv(1), 1);
        ticks(49);
        chk("rep_pre_first", dv(1), 1);
        ticks(1);
        chk("rep_first", dv(1), 2);
        ticks(10);
        chk("rep_second", dv(1), 3);
        ticks(10);
        chk("rep_third", dv(1), 4);
        ticks(5);
        pr_b = '0;
        ticks(20);
        chk("rep_total", dv(1), 4);
        chk("rep_rel", dr(1), 1);
        ticks(3);

        // 2x3 array: r1/c2, then two rows on column 0.
        base();
        exp_code[2] = 5;
        pr_c[5] = 1'b1;
        ticks(23);
        chk("small_accept", dv(2), 1);
        chk("small_code", int'(kc_c), 5);
        ticks(5);
        pr_c = '0;
        ticks(20);
        chk("small_rel", dr(2), 1);
        ticks(3);
        base();
        exp_code[2] = 0;
        pr_c[0] = 1'b1;
        pr_c[3] = 1'b1;
        ticks(21);
        chk("multi_accept", dv(2), 1);
        chk("multi_code", int'(kc_c), 0);
        pr_c = '0;
        ticks(20);
        chk("multi_rel", dr(2), 1);
        ticks(3);

        // Random single-key presses on all three instances at once.
        for (int k = 0; k < 6; k++) begin
            ka  = int'($urandom_range(0, 15));
            kb  = int'($urandom_range(0, 15));
            kcc = int'($urandom_range(0, 5));
            p   = 25 + int'($urandom_range(0, 80));
            exp_code[0] = ka;
            exp_code[1] = kb;
            exp_code[2] = kcc;
            ha = p - (21 + ka % 4);
            hb = p - (21 + kb % 4);
            base();
            pr_a[ka]  = 1'b1;
            pr_b[kb]  = 1'b1;
            pr_c[kcc] = 1'b1;
            ticks(p);
            pr_a = '0;
            pr_b = '0;
            pr_c = '0;
            ticks(19);
            chk("rnd_rel_early_a", dr(0), 0);
            chk("rnd_rel_early_b", dr(1), 0);
            chk("rnd_rel_early_c", dr(2), 0);
            ticks(1);
            chk("rnd_rel_a", dr(0), 1);
            chk("rnd_rel_b", dr(1), 1);
            chk("rnd_rel_c", dr(2), 1);
            chk("rnd_valid_a", dv(0), n_valid(ha, 1'b0));
            chk("rnd_valid_b", dv(1), n_valid(hb, 1'b1));
            chk("rnd_valid_c", dv(2), 1);
            chk("rnd_held_b", int'(kh_b), 0);
            ticks(3);
        end

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("code_at_pulse_%0d", i), ncb[i], 0);
            chk($sformatf("pulse_shape_%0d", i), nbad[i], 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
